// File: rtl/systolic_seq_pkg.sv
// Shared types, geometry constants and byte-index helpers for the
// 2x2-output systolic convolution sequencer.
package systolic_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

    localparam int N_PE        = 4;
    localparam int TAPS        = 9;
    localparam int FEED_CYCLES = 12;
    localparam int DATA_ROW    = 4;
    localparam int FILT_ROW    = 3;

    function automatic logic [3:0] data_idx(input logic [1:0] row, input logic [1:0] col);
        return 4'(int'(row) * DATA_ROW + int'(col));
    endfunction

    function automatic logic [3:0] filt_idx(input logic [1:0] i, input logic [1:0] j);
        return 4'(int'(i) * FILT_ROW + int'(j));
    endfunction

endpackage

// File: rtl/systolic_conv_sequencer_tap_select.sv
// Combinational operand selector for one PE: maps feed cycle n to the
// skewed tap t = n - K and picks the matching tile/filter bytes.
module conv_tap_select
    import systolic_seq_pkg::*;
#(
    parameter int DW = 8,
    parameter int K  = 0
) (
    input  logic             i_en,
    input  logic [3:0]       i_n,
    input  logic [16*DW-1:0] i_tile,
    input  logic [9*DW-1:0]  i_filt,
    output logic [DW-1:0]    o_a,
    output logic [DW-1:0]    o_w,
    output logic             o_valid,
    output logic             o_first
);

    localparam logic [3:0] K_N = 4'(K);
    localparam logic [1:0] ROW = 2'(K / 2);
    localparam logic [1:0] COL = 2'(K % 2);

    logic [3:0] w_t;
    logic [1:0] w_i;
    logic [1:0] w_j;
    logic       w_in_range;

    // w_i/w_j are only meaningful when the tap is in range
    assign w_t        = i_n - K_N;
    assign w_in_range = i_en && (i_n >= K_N) && (int'(w_t) < TAPS);
    assign w_i        = 2'(w_t / 4'd3);
    assign w_j        = 2'(w_t % 4'd3);

    always_comb begin
        o_a     = '0;
        o_w     = '0;
        o_valid = 1'b0;
        o_first = 1'b0;
        if (w_in_range) begin
            o_a     = i_tile[int'(data_idx(ROW + w_i, COL + w_j)) * DW +: DW];
            o_w     = i_filt[int'(filt_idx(w_i, w_j)) * DW +: DW];
            o_valid = 1'b1;
            o_first = (w_t == 4'd0);
        end
    end

endmodule

// File: rtl/systolic_conv_sequencer.sv
// Job sequencer for the 2x2-output systolic convolution array: latches a
// tile/filter, feeds skewed operands for 12 cycles, captures PE results.
//
// state | meaning
// IDLE  | in_ready high, waiting for a job
// FEED  | n = 0..11, streaming operands, capturing PE0-2 at n = 9..11
// DRAIN | one cycle, capturing PE3
// DONE  | res_valid high until res_ready
module systolic_conv_sequencer
    import systolic_seq_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [16*DW-1:0] zin,
    input  logic [9*DW-1:0]  filter,
    output logic [4*DW-1:0]  pe_a,
    output logic [4*DW-1:0]  pe_w,
    output logic [3:0]       pe_valid,
    output logic [3:0]       pe_first,
    input  logic [4*DW-1:0]  pe_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    out_c_0,
    output logic [DW-1:0]    out_c_1,
    output logic [DW-1:0]    out_c_2,
    output logic [DW-1:0]    out_c_3,
    output logic [2:0]       state
);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_n;
    logic [16*DW-1:0]    r_tile;
    logic [9*DW-1:0]     r_filt;
    logic [DW-1:0]       r_res [N_PE];
    logic                w_feed;
    logic                w_drain;
    logic                w_last_feed;

    assign w_last_feed = (r_n == 4'(FEED_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)    w_next = ST_FEED;
            ST_FEED:  if (w_last_feed) w_next = ST_DRAIN;
            ST_DRAIN:                  w_next = ST_DONE;
            ST_DONE:  if (res_ready)   w_next = ST_IDLE;
            default:                   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        res_valid = (r_state == ST_DONE);
        w_feed    = (r_state == ST_FEED);
        w_drain   = (r_state == ST_DRAIN);
    end

    // PE k finishes its last tap at n = k+8, so its accumulator is final at n = k+9
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n    <= '0;
            r_tile <= '0;
            r_filt <= '0;
            for (int k = 0; k < N_PE; k++) r_res[k] <= '0;
        end else begin
            if (in_ready && in_valid) begin
                r_tile <= zin;
                r_filt <= filter;
                r_n    <= '0;
            end
            if (w_feed) begin
                r_n <= w_last_feed ? 4'd0 : r_n + 4'd1;
                for (int k = 0; k < N_PE - 1; k++) begin
                    if (r_n == 4'(TAPS + k)) r_res[k] <= pe_acc[k*DW +: DW];
                end
            end
            if (w_drain) r_res[N_PE-1] <= pe_acc[(N_PE-1)*DW +: DW];
        end
    end

    for (genvar k = 0; k < N_PE; k++) begin : g_pe
        conv_tap_select #(.DW(DW), .K(k)) u_tap (
            .i_en    (w_feed),
            .i_n     (r_n),
            .i_tile  (r_tile),
            .i_filt  (r_filt),
            .o_a     (pe_a[k*DW +: DW]),
            .o_w     (pe_w[k*DW +: DW]),
            .o_valid (pe_valid[k]),
            .o_first (pe_first[k])
        );
    end

    assign out_c_0 = r_res[0];
    assign out_c_1 = r_res[1];
    assign out_c_2 = r_res[2];
    assign out_c_3 = r_res[3];
    assign state   = r_state;

endmodule

// File: tb/tb_systolic_conv_sequencer.sv
// Directed bench for systolic_conv_sequencer with a behavioural 8-bit PE model.
module tb_systolic_conv_sequencer;

    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [16*DW-1:0] zin;
    logic [9*DW-1:0]  filter;
    logic [4*DW-1:0]  pe_a;
    logic [4*DW-1:0]  pe_w;
    logic [3:0]       pe_valid;
    logic [3:0]       pe_first;
    logic [4*DW-1:0]  pe_acc;
    logic             res_valid;
    logic             res_ready;
    logic [DW-1:0]    out_c_0, out_c_1, out_c_2, out_c_3;
    logic [2:0]       state;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] d [16];
    logic [7:0] f [9];
    logic [7:0] acc [4];
    logic [7:0] outs [4];
    logic [7:0] exp1 [4];
    logic [7:0] exp_ones [4];

    systolic_conv_sequencer #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .zin(zin), .filter(filter), .pe_a(pe_a), .pe_w(pe_w),
        .pe_valid(pe_valid), .pe_first(pe_first), .pe_acc(pe_acc),
        .res_valid(res_valid), .res_ready(res_ready),
        .out_c_0(out_c_0), .out_c_1(out_c_1), .out_c_2(out_c_2), .out_c_3(out_c_3),
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mul8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = a * b;
        return p[7:0];
    endfunction

    // Behavioural PE: load on first, accumulate otherwise, 8-bit wrap
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) acc[k] <= 8'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pe_valid[k]) begin
                    if (pe_first[k]) acc[k] <= mul8(pe_a[k*8 +: 8], pe_w[k*8 +: 8]);
                    else             acc[k] <= acc[k] + mul8(pe_a[k*8 +: 8], pe_w[k*8 +: 8]);
                end
            end
        end
    end

    assign pe_acc  = {acc[3], acc[2], acc[1], acc[0]};
    assign outs[0] = out_c_0;
    assign outs[1] = out_c_1;
    assign outs[2] = out_c_2;
    assign outs[3] = out_c_3;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pack;
        for (int i = 0; i < 16; i++) zin[i*8 +: 8] = d[i];
        for (int i = 0; i < 9; i++) filter[i*8 +: 8] = f[i];
    endtask

    task automatic load_job1;
        d = '{8'd1, 8'd7, 8'd0, 8'd2,  8'd2, 8'd2, 8'd1, 8'd4,
              8'd3, 8'd6, 8'd7, 8'd5,  8'd4, 8'd4, 8'd2, 8'd3};
        f = '{8'd4, 8'd6, 8'd1,  8'd3, 8'd5, 8'd8,  8'd5, 8'd9, 8'd2};
        pack();
    endtask

    task automatic load_fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) d[i] = v;
        for (int i = 0; i < 9; i++) f[i] = v;
        pack();
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; zin = '0; filter = '0;
        #1;
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", state); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        vectors++; if (pe_valid !== 4'b0 || pe_first !== 4'b0) begin miscompares++; $display("FAIL reset_pe_ctl got=%b/%b exp=0000/0000", pe_valid, pe_first); end
        vectors++; if (pe_a !== '0 || pe_w !== '0) begin miscompares++; $display("FAIL reset_pe_data got=%h/%h exp=0", pe_a, pe_w); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (outs[k] !== 8'd0) begin miscompares++; $display("FAIL reset_out_c_%0d got=%0d exp=0", k, outs[k]); end
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic;
        int exp_state;
        load_job1(); res_ready = 1'b1; in_valid = 1'b1;
        vectors++; if (state !== 3'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_idle got=%0d/%b exp=0/1", state, in_ready); end
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            exp_state = (c <= 12) ? 1 : ((c == 13) ? 2 : 3);
            vectors++; if (int'(state) != exp_state) begin miscompares++; $display("FAIL basic_state cyc=%0d got=%0d exp=%0d", c, state, exp_state); end
            vectors++; if (res_valid !== (c == 14)) begin miscompares++; $display("FAIL basic_res_valid cyc=%0d got=%b exp=%b", c, res_valid, (c == 14)); end
            if (c == 1) begin
                vectors++; if (pe_valid !== 4'b0001 || pe_first !== 4'b0001) begin miscompares++; $display("FAIL basic_n0_ctl got=%b/%b exp=0001/0001", pe_valid, pe_first); end
                vectors++; if (pe_a !== 32'h0000_0001 || pe_w !== 32'h0000_0004) begin miscompares++; $display("FAIL basic_n0_data got=%h/%h exp=00000001/00000004", pe_a, pe_w); end
            end
            if (c == 5) begin
                vectors++; if (pe_valid !== 4'b1111 || pe_first !== 4'b0000) begin miscompares++; $display("FAIL basic_n4_ctl got=%b/%b exp=1111/0000", pe_valid, pe_first); end
                vectors++; if (pe_a !== {8'd1, 8'd1, 8'd2, 8'd2} || pe_w !== {8'd6, 8'd1, 8'd3, 8'd5}) begin miscompares++; $display("FAIL basic_n4_data got=%h/%h exp=01010202/06010305", pe_a, pe_w); end
            end
            if (c == 12) begin
                vectors++; if (pe_valid !== 4'b1000 || pe_first !== 4'b0000) begin miscompares++; $display("FAIL basic_n11_ctl got=%b/%b exp=1000/0000", pe_valid, pe_first); end
                vectors++; if (pe_a !== 32'h0300_0000 || pe_w !== 32'h0200_0000) begin miscompares++; $display("FAIL basic_n11_data got=%h/%h exp=03000000/02000000", pe_a, pe_w); end
            end
            if (c == 13) begin
                vectors++; if (pe_valid !== 4'b0000) begin miscompares++; $display("FAIL basic_drain_valid got=%b exp=0000", pe_valid); end
            end
            if (c == 14) begin
                for (int k = 0; k < 4; k++) begin
                    vectors++; if (outs[k] !== exp1[k]) begin miscompares++; $display("FAIL basic_out_c_%0d got=%0d exp=%0d", k, outs[k], exp1[k]); end
                end
            end
            if (c < 14) step();
        end
        step();
        vectors++; if (state !== 3'd0 || in_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL basic_return got=%0d/%b/%b exp=0/1/0", state, in_ready, res_valid); end
    endtask

    task automatic test_wrap;
        int cnt [4];
        int n;
        logic [3:0] ev, ef;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        load_fill(8'd255); res_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            n = c - 1;
            for (int k = 0; k < 4; k++) begin
                ev[k] = (n >= k) && (n <= k + 8);
                ef[k] = (n == k);
                if (pe_valid[k]) cnt[k]++;
            end
            vectors++; if (pe_valid !== ev || pe_first !== ef) begin miscompares++; $display("FAIL wrap_ctl n=%0d got=%b/%b exp=%b/%b", n, pe_valid, pe_first, ev, ef); end
            step();
        end
        step();
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_res_valid got=%b exp=1", res_valid); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (outs[k] !== 8'd9) begin miscompares++; $display("FAIL wrap_out_c_%0d got=%0d exp=9", k, outs[k]); end
            vectors++; if (cnt[k] != 9) begin miscompares++; $display("FAIL wrap_valid_count_%0d got=%0d exp=9", k, cnt[k]); end
        end
        step();
    endtask

    task automatic test_hold;
        load_job1(); res_ready = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (13) step();
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL hold_res_valid got=%b exp=1", res_valid); end
        for (int h = 0; h < 20; h++) begin
            if (h == 5) begin load_fill(8'd1); in_valid = 1'b1; end
            if (h == 7) in_valid = 1'b0;
            step();
            vectors++; if (state !== 3'd3 || in_ready !== 1'b0 || res_valid !== 1'b1) begin miscompares++; $display("FAIL hold_done h=%0d got=%0d/%b/%b exp=3/0/1", h, state, in_ready, res_valid); end
            for (int k = 0; k < 4; k++) begin
                vectors++; if (outs[k] !== exp1[k]) begin miscompares++; $display("FAIL hold_out_c_%0d h=%0d got=%0d exp=%0d", k, h, outs[k], exp1[k]); end
            end
        end
        res_ready = 1'b1;
        step();
        vectors++; if (state !== 3'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL hold_release got=%0d/%b exp=0/1", state, in_ready); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL hold_second_accept got=%0d exp=1", state); end
        repeat (13) step();
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL hold_second_res_valid got=%b exp=1", res_valid); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (outs[k] !== exp_ones[k]) begin miscompares++; $display("FAIL hold_second_out_c_%0d got=%0d exp=9", k, outs[k]); end
        end
        step();
    endtask

    task automatic test_reset_mid;
        load_job1(); res_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        vectors++; if (state !== 3'd1 || pe_valid !== 4'b1111) begin miscompares++; $display("FAIL rstmid_pre got=%0d/%b exp=1/1111", state, pe_valid); end
        rst = 1'b1;
        #1;
        vectors++; if (state !== 3'd0 || in_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_state got=%0d/%b/%b exp=0/1/0", state, in_ready, res_valid); end
        vectors++; if (pe_valid !== 4'b0 || pe_first !== 4'b0 || pe_a !== '0 || pe_w !== '0) begin miscompares++; $display("FAIL rstmid_pe got=%b/%b/%h/%h exp=0", pe_valid, pe_first, pe_a, pe_w); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (outs[k] !== 8'd0) begin miscompares++; $display("FAIL rstmid_out_c_%0d got=%0d exp=0", k, outs[k]); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (12) step();
        vectors++; if (state !== 3'd2 || res_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_drain got=%0d/%b exp=2/0", state, res_valid); end
        step();
        vectors++; if (state !== 3'd3 || res_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_done got=%0d/%b exp=3/1", state, res_valid); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (outs[k] !== exp1[k]) begin miscompares++; $display("FAIL rstmid_out_c_%0d got=%0d exp=%0d", k, outs[k], exp1[k]); end
        end
        step();
    endtask

    task automatic test_back_to_back;
        int busy;
        busy = 0;
        load_job1(); res_ready = 1'b1; in_valid = 1'b1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_first_ready got=%b exp=1", in_ready); end
        step();
        load_fill(8'd1);
        for (int c = 1; c <= 14; c++) begin
            if (in_ready === 1'b0) busy++;
            if (c == 14) begin
                for (int k = 0; k < 4; k++) begin
                    vectors++; if (outs[k] !== exp1[k]) begin miscompares++; $display("FAIL b2b_first_out_c_%0d got=%0d exp=%0d", k, outs[k], exp1[k]); end
                end
            end
            step();
        end
        vectors++; if (busy != 14) begin miscompares++; $display("FAIL b2b_busy_cycles got=%0d exp=14", busy); end
        vectors++; if (state !== 3'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_reaccept got=%0d/%b exp=0/1", state, in_ready); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (outs[k] !== exp1[k]) begin miscompares++; $display("FAIL b2b_hold_out_c_%0d got=%0d exp=%0d", k, outs[k], exp1[k]); end
        end
        step();
        vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL b2b_second_feed got=%0d exp=1", state); end
        repeat (13) step();
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_second_res_valid got=%b exp=1", res_valid); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (outs[k] !== exp_ones[k]) begin miscompares++; $display("FAIL b2b_second_out_c_%0d got=%0d exp=9", k, outs[k]); end
        end
        in_valid = 1'b0;
        step();
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL b2b_final_idle got=%0d exp=0", state); end
    endtask

    initial begin
        exp1     = '{8'd153, 8'd176, 8'd176, 8'd155};
        exp_ones = '{8'd9, 8'd9, 8'd9, 8'd9};
        test_reset();
        test_basic();
        test_wrap();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
